// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, NOP encoding, opcode field and FSM states.
package fetch_unit_pkg;

  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned INSTR_W_DEF = 12;

  // All-zero word is the architectural NOP.
  localparam logic [INSTR_W_DEF-1:0] NOP = 12'h000;

  localparam int unsigned OPCODE_HI = 11;
  localparam int unsigned OPCODE_LO = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWait,
    StHold
  } fetch_state_t;

  function automatic logic [OPCODE_HI-OPCODE_LO:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 12
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Fetch side issues requests and consumes responses.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side accepts requests and returns data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_skid_buf.sv
// One-entry holding buffer for an instruction and its pc+1 while execute is stalled.
module fetch_unit_skid_buf
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               inv_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc1_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc1_o
);

  localparam logic [INSTR_W-1:0] NopW = INSTR_W'(NOP);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc1_q;

  // Invalidate wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NopW;
      pc1_q   <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
      instr_q <= NopW;
      pc1_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc1_q   <= pc1_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc1_o   = pc1_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and drives the
// fetch-execute pipeline register (data, load, flush).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0] instruction_FE_in,
  output logic [PC_W-1:0]    pc_plus_1_FE_in,
  output logic               write_enable_FE,
  output logic               clear_FE
);

  localparam logic [INSTR_W-1:0] NopW = INSTR_W'(NOP);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;

  logic               buf_load, buf_inv, buf_valid;
  logic [INSTR_W-1:0] buf_instr;
  logic [PC_W-1:0]    buf_pc1;
  logic [PC_W-1:0]    pc_inc;
  logic               deliver;

  logic [INSTR_W-1:0] fe_instr;
  logic [PC_W-1:0]    fe_pc1;
  logic               fe_we, fe_clr;

  assign pc_inc = pc_q + PC_W'(1);

  fetch_unit_skid_buf #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_skid_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (buf_load),
    .inv_i  (buf_inv),
    .instr_i(imem.imem_rdata),
    .pc1_i  (pc_inc),
    .valid_o(buf_valid),
    .instr_o(buf_instr),
    .pc1_o  (buf_pc1)
  );

  // Next-state, PC update and FE register controls.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    buf_load = 1'b0;
    buf_inv  = 1'b0;
    deliver  = 1'b0;
    fe_we    = 1'b0;
    fe_clr   = 1'b0;
    fe_instr = NopW;
    fe_pc1   = '0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem.imem_ready) state_d = StWait;
      end
      StWait: begin
        if (imem.imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StFetch;
          end else if (!stall_in) begin
            deliver  = 1'b1;
            fe_instr = imem.imem_rdata;
            fe_pc1   = pc_inc;
            pc_d     = pc_inc;
            state_d  = StFetch;
          end else begin
            buf_load = 1'b1;
            state_d  = StHold;
          end
        end
      end
      StHold: begin
        if (!stall_in && buf_valid) begin
          deliver  = 1'b1;
          fe_instr = buf_instr;
          fe_pc1   = buf_pc1;
          pc_d     = pc_inc;
          buf_inv  = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Load the FE register with either the delivered word or a NOP bubble.
    if (state_q != StIdle && !stall_in) fe_we = 1'b1;
    if (!deliver) begin
      fe_instr = NopW;
      fe_pc1   = '0;
    end

    // Redirect overrides everything; a request still in flight must have its response dropped.
    if (redirect_valid && state_q != StIdle) begin
      fe_we    = 1'b0;
      fe_clr   = 1'b1;
      fe_instr = NopW;
      fe_pc1   = '0;
      pc_d     = redirect_pc;
      buf_load = 1'b0;
      buf_inv  = 1'b1;
      if ((state_q == StWait && !imem.imem_rvalid) ||
          (state_q == StFetch && imem.imem_ready)) begin
        state_d = StWait;
        drop_d  = 1'b1;
      end else begin
        state_d = StFetch;
        drop_d  = 1'b0;
      end
    end
  end

  // FSM and PC state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  assign imem.imem_req     = (state_q == StFetch);
  assign imem.imem_addr    = pc_q;
  assign instruction_FE_in = fe_instr;
  assign pc_plus_1_FE_in   = fe_pc1;
  assign write_enable_FE   = fe_we;
  assign clear_FE          = fe_clr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected deliveries, a monitor pops and checks.
module tb_fetch_unit;

  localparam logic [11:0] NOP_W = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic [11:0] instruction_FE_in;
  logic [9:0]  pc_plus_1_FE_in;
  logic        write_enable_FE;
  logic        clear_FE;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_q[$];

  fetch_unit_if #(.PC_W(10), .INSTR_W(12)) mem ();

  fetch_unit #(.PC_W(10), .INSTR_W(12), .RESET_PC(10'd0)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem             (mem),
    .instruction_FE_in(instruction_FE_in),
    .pc_plus_1_FE_in  (pc_plus_1_FE_in),
    .write_enable_FE  (write_enable_FE),
    .clear_FE         (clear_FE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every real delivery (non-NOP load) must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && write_enable_FE && instruction_FE_in !== NOP_W) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_delivery: got instr %0h pc1 %0h expected none",
                 instruction_FE_in, pc_plus_1_FE_in);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        chk("deliver_instr", 32'(instruction_FE_in), 32'(e[21:10]));
        chk("deliver_pc1", 32'(pc_plus_1_FE_in), 32'(e[9:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Wait (bounded) for a request and check its address; n = cycles waited.
  task automatic wait_req(input logic [9:0] a, input string nm, output int n);
    n = 0;
    smp();
    while (!mem.imem_req && n < 8) begin
      cyc();
      smp();
      n++;
    end
    chk({nm, "_req"}, 32'(mem.imem_req), 32'd1);
    chk({nm, "_addr"}, 32'(mem.imem_addr), 32'(a));
  endtask

  // Accept a request at address a and return data d one cycle later, stall-free.
  task automatic do_fetch(input logic [9:0] a, input logic [11:0] d, input string nm,
                          input bit immediate);
    int n;
    logic [9:0] p1;
    wait_req(a, nm, n);
    if (immediate) chk({nm, "_latency"}, 32'(n), 32'd0);
    cyc();
    p1 = a + 10'd1;
    exp_q.push_back({d, p1});
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = d;
    smp();
    chk({nm, "_we"}, 32'(write_enable_FE), 32'd1);
    cyc();
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mem.imem_ready  = 1'b1;
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;

    // Reset state.
    smp();
    chk("rst_req", 32'(mem.imem_req), 32'd0);
    chk("rst_we", 32'(write_enable_FE), 32'd0);
    chk("rst_clr", 32'(clear_FE), 32'd0);
    chk("rst_instr", 32'(instruction_FE_in), 32'(NOP_W));
    cyc();
    cyc();
    rst = 1'b0;
    smp();
    chk("idle_req", 32'(mem.imem_req), 32'd0);
    chk("idle_we", 32'(write_enable_FE), 32'd0);
    cyc();

    // First fetch at RESET_PC, then straight-line fetches up to pc 5.
    do_fetch(10'd0, 12'hA05, "first", 1'b1);
    for (int i = 1; i < 5; i++) do_fetch(10'(i), 12'h800 | 12'(i), "seq", 1'b1);

    // Stall around the response at pc 5.
    begin
      int n;
      wait_req(10'd5, "stall", n);
    end
    cyc();
    stall_in = 1'b1;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 12'h3C1;
    smp();
    chk("stall_we0", 32'(write_enable_FE), 32'd0);
    cyc();
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("hold_we", 32'(write_enable_FE), 32'd0);
      chk("hold_req", 32'(mem.imem_req), 32'd0);
      cyc();
    end
    exp_q.push_back({12'h3C1, 10'd6});
    stall_in = 1'b0;
    smp();
    chk("release_we", 32'(write_enable_FE), 32'd1);
    cyc();

    // Redirect while a request is outstanding: stale response dropped.
    begin
      int n;
      wait_req(10'd6, "redir_wait", n);
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h200;
    smp();
    chk("redir_clr", 32'(clear_FE), 32'd1);
    chk("redir_we", 32'(write_enable_FE), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 12'h806;
    smp();
    chk("drop_req", 32'(mem.imem_req), 32'd0);
    chk("drop_instr", 32'(instruction_FE_in), 32'(NOP_W));
    cyc();
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;
    do_fetch(10'h200, 12'hA00, "redir_target", 1'b1);

    // Redirect coincident with rvalid and stall: nothing buffered, next fetch at target.
    begin
      int n;
      wait_req(10'h201, "coin", n);
    end
    cyc();
    stall_in = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FF;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 12'hBAD;
    smp();
    chk("coin_clr", 32'(clear_FE), 32'd1);
    chk("coin_we", 32'(write_enable_FE), 32'd0);
    cyc();
    stall_in = 1'b0;
    redirect_valid = 1'b0;
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;

    // Fetch at 0x3FF wraps pc_plus_1 and the next address to 0.
    do_fetch(10'h3FF, 12'h7FF, "wrap", 1'b1);
    begin
      int n;
      wait_req(10'd0, "wrap_next", n);
      chk("wrap_next_latency", 32'(n), 32'd0);
    end
    cyc();

    // Reset while WAIT; late response after release must be ignored.
    rst = 1'b1;
    smp();
    chk("mid_rst_req", 32'(mem.imem_req), 32'd0);
    chk("mid_rst_we", 32'(write_enable_FE), 32'd0);
    chk("mid_rst_instr", 32'(instruction_FE_in), 32'(NOP_W));
    chk("mid_rst_pc1", 32'(pc_plus_1_FE_in), 32'd0);
    cyc();
    rst = 1'b0;
    mem.imem_rvalid = 1'b1;
    mem.imem_rdata  = 12'hEEE;
    smp();
    chk("late_rvalid_we", 32'(write_enable_FE), 32'd0);
    cyc();
    mem.imem_rvalid = 1'b0;
    mem.imem_rdata  = '0;
    do_fetch(10'd0, 12'hA05, "restart", 1'b1);

    repeat (3) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
